// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 UART link. The transmitter and the
// receive decoder both use these.
//   CMD_*          command byte codes carried at the end of each frame
//   CHAR_CR        frame terminator
//   hex_ascii()    nibble -> uppercase ASCII hex character
//   ser_state_t    byte serializer sequencing states
//   tx_state_t     frame-level transmitter states
package sha256_pkg;

    localparam logic [7:0] CMD_HASH        = 8'h01;
    localparam logic [7:0] CMD_READ_DIGEST = 8'h02;
    localparam logic [7:0] CMD_READ_HI     = 8'h03;
    localparam logic [7:0] CMD_READ_LO     = 8'h04;

    localparam logic [7:0] CHAR_CR = 8'h0D;

    // Index of the last character in a frame (chars are numbered from 0).
    localparam int CHUNK_CHARS    = 128;
    localparam int HASH_LAST_IDX  = 130;
    localparam int SHORT_LAST_IDX = 2;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_FRAME = 1'b1
    } tx_state_t;

    // 0-9 -> '0'..'9' (0x30..0x39), A-F -> 'A'..'F' (0x41..0x46).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            hex_ascii = 8'h30 + wide;
        end else begin
            hex_ascii = 8'h37 + wide;
        end
    endfunction

endpackage

// File: rtl/host_byte_ser.sv
// host_byte_ser
// 8N1 byte serializer: start bit (0), 8 data bits LSB first, stop bit (1),
// each held for BAUD_DIV clock cycles. Line idles high.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   load, data   byte hand-off from the frame controller
//   ready        serializer can take a byte at the coming clock edge
//   tx           UART line (registered)
//   state        current sequencing state, for observation
//
// Handshake: a byte is taken on a clock edge where load and ready are both
// high. ready is high while idle and also during the final cycle of a stop
// bit, so a byte loaded then starts its start bit on the very next cycle and
// consecutive bytes run back to back with no idle gap.
module host_byte_ser
    import sha256_pkg::*;
#(
    parameter int BAUD_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output ser_state_t state
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          last_baud;

    assign last_baud = (baud_cnt == CW'(BAUD_DIV - 1));
    assign ready     = (state == SER_IDLE) || ((state == SER_STOP) && last_baud);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SER_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (load && ready) begin
            state    <= SER_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= data;
        end else begin
            case (state)
                SER_IDLE: begin
                    tx <= 1'b1;
                end
                SER_START: begin
                    if (last_baud) begin
                        baud_cnt <= '0;
                        state    <= SER_DATA;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SER_DATA: begin
                    if (last_baud) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= SER_STOP;
                            tx      <= 1'b1;
                        end else begin
                            // shreg[0] is always the bit on the line.
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SER_STOP: begin
                    // Final stop cycle without a new byte: drop to idle.
                    if (last_baud) begin
                        baud_cnt <= '0;
                        state    <= SER_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SER_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sha256_host_tx.sv
// sha256_host_tx
// Host-side request transmitter for the SHA-256 UART link. Frames a command
// (and for CMD_HASH a 512-bit chunk) as uppercase ASCII hex terminated by CR
// and sends it as 8N1 UART.
//   CMD_HASH : 128 chunk chars (chunk[511:508] first), 2 cmd chars, CR
//   other    : 2 cmd chars, CR
// Ports:
//   Clk, Reset   clock, synchronous active-high reset
//   Start        request strobe, taken only while Busy=0
//   Command      command byte, latched on accept
//   Chunk        512-bit block, latched on accept
//   Tx           UART line, idles high
//   Busy         frame in progress
//   Done         one-cycle pulse after the final stop bit
module sha256_host_tx
    import sha256_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [7:0]   Command,
    input  logic [511:0] Chunk,
    output logic         Tx,
    output logic         Busy,
    output logic         Done
);

    tx_state_t    state;
    ser_state_t   ser_state;
    logic [7:0]   cmd_q;
    logic [511:0] chunk_q;   // shifted left one nibble per char sent
    logic [7:0]   idx;       // index of the char currently on the line
    logic [7:0]   last_idx;

    logic         ser_load;
    logic         ser_ready;
    logic [7:0]   ser_data;
    logic         accept;
    logic         next_char;

    logic [7:0]   sel_cmd;
    logic [3:0]   sel_nib;
    logic [7:0]   sel_idx;

    // Character at position i of the frame for command cmd; nib is the chunk
    // nibble belonging to that position.
    function automatic logic [7:0] char_at(input logic [7:0] cmd,
                                           input logic [3:0] nib,
                                           input logic [7:0] i);
        logic [7:0] tail;
        logic [7:0] ch;
        tail = (cmd == CMD_HASH) ? (i - 8'(CHUNK_CHARS)) : i;
        if ((cmd == CMD_HASH) && (i < 8'(CHUNK_CHARS))) begin
            ch = hex_ascii(nib);
        end else if (tail == 8'd0) begin
            ch = hex_ascii(cmd[7:4]);
        end else if (tail == 8'd1) begin
            ch = hex_ascii(cmd[3:0]);
        end else begin
            ch = CHAR_CR;
        end
        return ch;
    endfunction

    assign accept    = (state == TX_IDLE) && Start;
    assign next_char = (state == TX_FRAME) && ser_ready && (idx != last_idx);
    assign ser_load  = accept || next_char;

    // The next char is encoded combinationally so it is handed over on the
    // accept edge or the last stop-bit edge; loading costs no line time.
    // On accept, encode straight from the inputs since nothing is latched yet.
    always_comb begin
        sel_cmd = cmd_q;
        sel_nib = chunk_q[511:508];
        sel_idx = idx + 8'd1;
        if (state == TX_IDLE) begin
            sel_cmd = Command;
            sel_nib = Chunk[511:508];
            sel_idx = 8'd0;
        end
        ser_data = char_at(sel_cmd, sel_nib, sel_idx);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= TX_IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            cmd_q    <= '0;
            chunk_q  <= '0;
            idx      <= '0;
            last_idx <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (Start) begin
                        cmd_q    <= Command;
                        chunk_q  <= Chunk << 4;
                        idx      <= '0;
                        last_idx <= (Command == CMD_HASH) ? 8'(HASH_LAST_IDX)
                                                          : 8'(SHORT_LAST_IDX);
                        Busy     <= 1'b1;
                        state    <= TX_FRAME;
                    end
                end
                TX_FRAME: begin
                    if (ser_ready) begin
                        if (idx == last_idx) begin
                            state <= TX_IDLE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            idx   <= '0;
                        end else begin
                            idx     <= idx + 8'd1;
                            chunk_q <= chunk_q << 4;
                        end
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    host_byte_ser #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ser (
        .clk   (Clk),
        .reset (Reset),
        .load  (ser_load),
        .data  (ser_data),
        .ready (ser_ready),
        .tx    (Tx),
        .state (ser_state)
    );

    // Serializer state is kept for observation only.
    logic ser_state_unused;
    assign ser_state_unused = ^ser_state;

endmodule

// File: doc/sha256_host_tx.md
# sha256_host_tx

Host-side request transmitter for the SHA-256 UART link. It frames a 512-bit chunk and/or an 8-bit command as ASCII hex characters and serializes them as 8N1 UART on `Tx`, producing the exact byte stream the FPGA command receiver consumes. It is used in the loopback bench and in the two-board setup, where a second FPGA drives requests into the hash unit.

## Interface
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `BAUD_DIV`, default CLK_HZ/BAUD (integer division, must be ≥ 2): cycles per bit.

- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  request strobe, sampled only while `Busy`=0.
- `Command`  in  8  command byte: 01 hash, 02 read digest, 03 read chunk[511:256], 04 read chunk[255:0].
- `Chunk`  in  512  message block; used only when `Command`=01.
- `Tx`  out  1  UART line; idles high.
- `Busy`  out  1  frame in progress.
- `Done`  out  1  one-cycle pulse when the final stop bit ends.

## Operation
- **Accept.** On `Start`=1 with `Busy`=0, latch `Command` and `Chunk`. `Start` while `Busy`=1 is ignored and not queued.
- **Frame for `Command`=01.** 128 chunk chars, MSB nibble first (chunk[511:508] first), then 2 command chars (high nibble first), then CR (0x0D). Total 131 bytes.
- **Frame for any other command.** 2 command chars, then CR. Total 3 bytes. Unknown codes are still transmitted unchanged.
- **Hex encoding.** Nibble 0–9 maps to 0x30–0x39; nibble A–F maps to 0x41–0x46 (uppercase).
- **Byte format.** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No gap between bytes: the next start bit follows the stop bit directly.
- **FSM states:**
  - IDLE → LOAD on accept.
  - LOAD selects and encodes the current char, then → START.
  - START → DATA after BAUD_DIV cycles.
  - DATA → STOP after 8 bit periods.
  - STOP → LOAD when more chars remain; otherwise → IDLE and pulse `Done`.
- **Counters:**
  - Baud counter 0..BAUD_DIV-1.
  - Bit counter 0..7.
  - Char index 0..130, 8 bits wide; the last index is 130 for cmd 01 and 2 otherwise.
- **LOAD** is absorbed into the final cycle of the previous stop bit (or the accept cycle), so it adds no line time.

## Timing
- **Reset values:** `Tx`=1, `Busy`=0, `Done`=0, FSM=IDLE, all counters 0.
- **Start latency.** With `Start` high in cycle N, `Busy`=1 and `Tx`=0 (start bit) from cycle N+1.
- **Line timing.** Each bit holds exactly BAUD_DIV cycles. A frame lasts bytes×10×BAUD_DIV cycles.
- **End of frame.** `Done`=1 for one cycle, in the cycle after the last stop bit's final cycle. `Busy` falls in that same cycle. `Tx` stays 1.
- **Back-to-back.** `Start` in the `Done` cycle is accepted, because `Busy`=0 there. The next start bit appears one cycle later, giving a 1-cycle idle-high gap.
- **Reset mid-frame.** The frame is aborted. `Tx`=1 the next cycle, no `Done` pulse, latched data discarded.
- **Input stability.** `Chunk`/`Command` may change freely after the accept cycle.

## Structure
- **Shared package `sha256_pkg`:**
  - Command codes CMD_HASH=8'h01, CMD_READ_DIGEST=8'h02, CMD_READ_HI=8'h03, CMD_READ_LO=8'h04.
  - CHAR_CR=8'h0D.
  - Nibble-to-ASCII function `hex_ascii`.
  - These are shared with the receive decoder.
- **Sub-module `host_byte_ser`:**
  - Owns the baud counter, bit counter, and START/DATA/STOP sequencing.
  - Handshake: `load`/`data[7:0]` in, `ready` out.
  - The top level owns IDLE/LOAD, the char index, and encoding.

## Test plan
All tests use `CLK_HZ`=8, `BAUD`=1, so BAUD_DIV=8.

1. **Reset.** Hold `Reset` for 3 cycles → `Tx`=1, `Busy`=0, `Done`=0 throughout, and for 20 cycles after release with no `Start`.
2. **Command 02.** `Start` with `Command`=8'h02 → decoded bytes 0x30, 0x32, 0x0D. Each bit lasts 8 cycles. `Done` pulses at cycle 241 after `Start`. `Busy` is high for cycles 1–240.
3. **Command 01.** `Chunk`=512'h6162638000…0018, `Command`=8'h01 → 131 bytes:
   - First chars "616263800000…".
   - Chunk chars end "…0018".
   - Then "01" and CR.
   - `Done` at cycle 10481.
4. **Ignored start.** `Start` pulsed mid-frame with a different command → ignored: byte count and content of the first frame unchanged, no second frame.
5. **Back-to-back.** `Start` (cmd 03) asserted in the `Done` cycle of a cmd 04 frame → second frame "03\r" begins after exactly one idle-high cycle.
6. **Reset mid-frame.** `Reset` during data bit 4 of the 70th byte of a cmd 01 frame → `Tx`=1 the next cycle, no `Done`. A new cmd 02 `Start` then yields a clean "02\r".
